// File: rtl/fruit_rom_arb_pkg.sv
// Shared types and constants for the fruit-template ROM read arbiter.
package fruit_rom_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // Sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                last;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    localparam int RD_LAT_NO_OREG = 1;
    localparam int RD_LAT_OREG    = 2;

endpackage

// File: rtl/fruit_rr_pick.sv
// Combinational round-robin picker: first set request bit above ptr, wrapping.
module fruit_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] cand;

    // NOTE: every output gets a default before the search loop, so no path leaves a latch.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fruit_rom_rd_arbiter.sv
// Round-robin burst read arbiter in front of a single-port template ROM,
// returning latency-aligned read data tagged with requester id and last flag.
module fruit_rom_rd_arbiter
    import fruit_rom_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int RD_LATENCY = RD_LAT_NO_OREG,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    output logic                            rom_clk_en,
    input  logic [DATA_WIDTH-1:0]           rom_rd_data,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [ID_WIDTH-1:0]             rd_id,
    output logic                            rd_last
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (RD_LATENCY < RD_LAT_NO_OREG || RD_LATENCY > RD_LAT_OREG) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end
    if (ID_WIDTH < IDX_W) begin : g_bad_id_width
        $error("ID_WIDTH too narrow for NUM_REQ");
    end

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
    logic [TAG_W-1:0]      pipe_q [RD_LATENCY];
    logic [TAG_W-1:0]      pipe_d [RD_LATENCY];

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  issue;
    logic                  pipe_busy;
    tag_t                  head;
    tag_t                  tail;
    tag_t                  stage;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            len_arr[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    fruit_rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign issue = (state_q == ST_ISSUE);

    // The grant is a combinational pulse from live req; gating with rst_n keeps it low during reset.
    assign gnt = (state_q == ST_IDLE && rst_n) ? pick_gnt : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_addr_d = cur_addr_q;
        cnt_d      = cnt_q;
        cur_id_d   = cur_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    ptr_d      = pick_idx;
                    cur_id_d   = ID_WIDTH'(pick_idx);
                    cur_addr_d = addr_arr[pick_idx];
                    cnt_d      = len_arr[pick_idx];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == '0) begin
                    // Address is left on the final word so rom_addr holds while idle.
                    state_d = ST_IDLE;
                end else begin
                    cur_addr_d = cur_addr_q + 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        head = '0;
        if (issue) begin
            head.valid = 1'b1;
            head.id    = TAG_ID_W'(cur_id_q);
            head.last  = (cnt_q == '0);
        end
        pipe_d[0] = head;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        stage     = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            stage     = pipe_q[i];
            pipe_busy = pipe_busy | stage.valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            cur_addr_q <= '0;
            cnt_q      <= '0;
            cur_id_q   <= '0;
            // NOTE: the tag pipe is reset because its valid bits decide whether stale data escapes.
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_addr_q <= cur_addr_d;
            cnt_q      <= cnt_d;
            cur_id_q   <= cur_id_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tail       = pipe_q[RD_LATENCY-1];
    assign rom_clk_en = issue;
    assign rom_addr   = cur_addr_q;
    assign busy       = issue | pipe_busy;
    assign rd_valid   = tail.valid;
    assign rd_id      = ID_WIDTH'(tail.id);
    assign rd_last    = tail.last;
    assign rd_data    = rom_rd_data;

endmodule

// File: tb/tb_fruit_rom_rd_arbiter.sv
// Self-checking bench: two arbiter instances (ROM latency 1 and 2) share stimulus
// and are compared every cycle against a cycle-indexed schedule model.
module tb_fruit_rom_rd_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [39:0] req_addr;
    logic [31:0] req_len;

    logic [3:0]  gnt_1, gnt_2;
    logic        busy_1, busy_2;
    logic [9:0]  rom_addr_1, rom_addr_2;
    logic        rom_clk_en_1, rom_clk_en_2;
    logic [31:0] rom_q1, rom_s2, rom_q2;
    logic        rd_valid_1, rd_valid_2;
    logic [31:0] rd_data_1, rd_data_2;
    logic [1:0]  rd_id_1, rd_id_2;
    logic        rd_last_1, rd_last_2;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: expected issue schedule keyed by absolute cycle number.
    int         iss_addr [int];
    int         iss_id   [int];
    bit         iss_last [int];
    int         free_at  = 0;
    int         m_ptr    = NREQ - 1;
    int         last_addr = 0;
    logic [3:0] exp_gnt  = '0;
    logic [3:0] last_gnt = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fruit_rom_rd_arbiter #(.RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt_1), .busy(busy_1), .rom_addr(rom_addr_1), .rom_clk_en(rom_clk_en_1),
        .rom_rd_data(rom_q1), .rd_valid(rd_valid_1), .rd_data(rd_data_1),
        .rd_id(rd_id_1), .rd_last(rd_last_1)
    );

    fruit_rom_rd_arbiter #(.RD_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt_2), .busy(busy_2), .rom_addr(rom_addr_2), .rom_clk_en(rom_clk_en_2),
        .rom_rd_data(rom_q2), .rd_valid(rd_valid_2), .rd_data(rd_data_2),
        .rd_id(rd_id_2), .rd_last(rd_last_2)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // ROM models: array read gated by clk_en, optional output register always clocked.
    always @(posedge clk) begin
        if (rom_clk_en_1) rom_q1 <= rom_word(rom_addr_1);
        if (rom_clk_en_2) rom_s2 <= rom_word(rom_addr_2);
        rom_q2 <= rom_s2;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input string nm, input int lat, input logic [3:0] g, input logic bsy,
                              input logic [9:0] ra, input logic ce, input logic v,
                              input logic [31:0] d, input logic [1:0] id, input logic lst);
        bit issuing, inflight, ret;
        issuing  = iss_addr.exists(cyc) != 0;
        inflight = 1'b0;
        for (int t = cyc - lat; t < cyc; t++) begin
            if (iss_addr.exists(t) != 0) inflight = 1'b1;
        end
        ret = iss_addr.exists(cyc - lat) != 0;
        check({nm, " gnt"}, 32'(g), 32'(exp_gnt));
        check({nm, " rom_clk_en"}, 32'(ce), 32'(issuing));
        check({nm, " rom_addr"}, 32'(ra), 32'(last_addr));
        check({nm, " busy"}, 32'(bsy), 32'(issuing | inflight));
        check({nm, " rd_valid"}, 32'(v), 32'(ret));
        if (ret) begin
            check({nm, " rd_id"}, 32'(id), 32'(iss_id[cyc-lat]));
            check({nm, " rd_last"}, 32'(lst), 32'(iss_last[cyc-lat]));
            check({nm, " rd_data"}, d, rom_word(10'(iss_addr[cyc-lat])));
        end
    endtask

    // Model + compare process.
    always @(negedge clk) begin
        if (!rst_n) begin
            iss_addr.delete();
            iss_id.delete();
            iss_last.delete();
            free_at   = 0;
            m_ptr     = NREQ - 1;
            last_addr = 0;
            exp_gnt   = '0;
            check("rst gnt_1", 32'(gnt_1), 0);
            check("rst busy_1", 32'(busy_1), 0);
            check("rst rom_addr_1", 32'(rom_addr_1), 0);
            check("rst rom_clk_en_1", 32'(rom_clk_en_1), 0);
            check("rst rd_valid_1", 32'(rd_valid_1), 0);
            check("rst rd_id_1", 32'(rd_id_1), 0);
            check("rst rd_last_1", 32'(rd_last_1), 0);
            check("rst busy_2", 32'(busy_2), 0);
            check("rst rom_addr_2", 32'(rom_addr_2), 0);
            check("rst rd_valid_2", 32'(rd_valid_2), 0);
            check("rst rd_last_2", 32'(rd_last_2), 0);
        end else begin
            exp_gnt = '0;
            if (cyc >= free_at && req != '0) begin
                int j;
                logic [9:0] a;
                logic [7:0] l;
                j = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (j < 0 && req[(m_ptr + k) % NREQ]) j = (m_ptr + k) % NREQ;
                end
                exp_gnt[j] = 1'b1;
                m_ptr = j;
                a = req_addr[j*10 +: 10];
                l = req_len[j*8 +: 8];
                for (int w = 0; w <= int'(l); w++) begin
                    iss_addr[cyc+1+w] = (int'(a) + w) % 1024;
                    iss_id[cyc+1+w]   = j;
                    iss_last[cyc+1+w] = (w == int'(l));
                end
                free_at = cyc + int'(l) + 2;
            end
            if (iss_addr.exists(cyc) != 0) last_addr = iss_addr[cyc];
            check_inst("lat1", 1, gnt_1, busy_1, rom_addr_1, rom_clk_en_1, rd_valid_1, rd_data_1, rd_id_1, rd_last_1);
            check_inst("lat2", 2, gnt_2, busy_2, rom_addr_2, rom_clk_en_2, rd_valid_2, rd_data_2, rd_id_2, rd_last_2);
        end
        last_gnt = exp_gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [9:0] a, input logic [7:0] l);
        req[i]            = 1'b1;
        req_addr[i*10 +: 10] = a;
        req_len[i*8 +: 8]    = l;
    endtask

    logic [3:0] gq [$];
    logic [3:0] exp_order [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [9:0] wrap_exp  [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [9:0] vvec;
    logic       busy8, busy9;
    logic [3:0] gacc;

    initial begin
        rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single burst, requester 2, four words.
        set_req(2, 10'h010, 8'd3);
        @(negedge clk); check("p1 gnt", 32'(gnt_1), 32'h4);
        tick(); req = '0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            check("p1 rom_addr", 32'(rom_addr_1), 32'(10'h010) + w);
            check("p1 rom_clk_en", 32'(rom_clk_en_1), 1);
            tick();
        end
        @(negedge clk);
        check("p1 last valid", 32'(rd_valid_1), 1);
        check("p1 last flag", 32'(rd_last_1), 1);
        check("p1 last id", 32'(rd_id_1), 2);
        check("p1 last data", rd_data_1, 32'hA5A5_0000 ^ (32'h13 * 32'h9E37_79B1));
        repeat (3) tick();

        // Round-robin from reset with all requests held.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 10'(i * 64), 8'd0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (gnt_1 != '0) gq.push_back(gnt_1);
            tick();
        end
        req = '0;
        check("p2 grant count", gq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gq.size()) check("p2 grant order", 32'(gq[i]), 32'(exp_order[i]));
        end
        repeat (3) tick();

        // Address wrap-around.
        set_req(0, 10'h3FE, 8'd3);
        @(negedge clk);
        tick(); req = '0;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            check("p3 wrap addr", 32'(rom_addr_1), 32'(wrap_exp[w]));
            tick();
        end
        repeat (3) tick();

        // Latency-2 back-to-back bursts.
        do_reset();
        set_req(0, 10'h020, 8'd1);
        set_req(1, 10'h030, 8'd2);
        vvec = '0; busy8 = 1'b0; busy9 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vvec[k] = rd_valid_2;
            if (k == 8) busy8 = busy_2;
            if (k == 9) busy9 = busy_2;
            tick();
            if (k == 0) req[0] = 1'b0;
            if (k == 3) req[1] = 1'b0;
        end
        check("p4 valid pattern", 32'(vvec), 32'h1D8);
        check("p4 busy tail", 32'(busy8), 1);
        check("p4 busy end", 32'(busy9), 0);

        // Reset during the third issue of an eight-word burst.
        set_req(2, 10'h100, 8'd7);
        tick(); req = '0;
        tick();
        tick();
        rst_n = 1'b0;
        req = 4'b1111; req_len = '0;
        @(negedge clk);
        check("p5 gnt", 32'(gnt_1), 0);
        check("p5 rom_clk_en", 32'(rom_clk_en_1), 0);
        check("p5 rd_valid_2", 32'(rd_valid_2), 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("p5 first grant", 32'(gnt_1), 32'h1);
        tick(); req = '0;
        repeat (6) tick();

        // Withdrawn request during another burst.
        set_req(3, 10'h200, 8'd5);
        gacc = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            gacc = gacc | gnt_1;
            tick();
            if (k == 0) req = '0;
            if (k == 1) set_req(1, 10'h050, 8'd0);
            if (k == 2) req = '0;
        end
        check("p6 grants seen", 32'(gacc), 32'h8);
        @(negedge clk);
        check("p6 busy_1 idle", 32'(busy_1), 0);
        check("p6 busy_2 idle", 32'(busy_2), 0);
        tick();

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && last_gnt[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 10'($urandom_range(0, 1023)), 8'($urandom_range(0, 6)));
                    else
                        req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 29) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        set_req(i, 10'($urandom_range(1018, 1023)), 8'($urandom_range(0, 6)));
                    else
                        set_req(i, 10'($urandom_range(0, 1023)), 8'($urandom_range(0, 6)));
                end
            end
        end
        req = '0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
